// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        GNT_F,
        GNT_D
    } grant_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_arb_starve.sv
// Starvation counter: counts data wins over a waiting fetch and raises
// fetch_override once the limit is reached.
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   grant,
    input  grant_t winner,
    input  logic   f_req,
    output logic   fetch_override
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking assignments.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == GNT_F || !f_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // With a limit of zero the counter sits at 0, so fetch always wins a tie.
    assign fetch_override = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store; data has
// priority, bounded by the starvation counter. One transaction per 4 cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    input  logic [DATA_W-1:0] m_data_out,
    output logic              m_rw,
    output logic              m_en
);

    state_t            state;
    grant_t            gnt;
    grant_t            winner;
    logic              gnt_we;
    logic              grant_event;
    logic              fetch_override;
    logic              sel_we;
    logic              sel_misaligned;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        winner         = (f_req && (!d_req || fetch_override)) ? GNT_F : GNT_D;
        grant_event    = (state == IDLE) && (f_req || d_req);
        sel_addr       = (winner == GNT_F) ? f_addr : d_addr;
        sel_we         = (winner == GNT_D) && d_we;
        sel_wdata      = (winner == GNT_D) ? d_wdata : '0;
        sel_misaligned = (sel_addr[1:0] != 2'b00);
    end

    mem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock          (clock),
        .reset          (reset),
        .grant          (grant_event),
        .winner         (winner),
        .f_req          (f_req),
        .fetch_override (fetch_override)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= GNT_F;
            gnt_we    <= 1'b0;
            m_en      <= 1'b0;
            m_rw      <= RW_READ;
            m_addr    <= '0;
            m_data_in <= '0;
            f_ack     <= 1'b0;
            f_rdata   <= '0;
            f_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            // Response outputs are pulses: zero unless this edge raises an ack.
            f_ack   <= 1'b0;
            f_rdata <= '0;
            f_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
            m_en    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_event) begin
                        gnt    <= winner;
                        gnt_we <= sel_we;
                        if (sel_misaligned) begin
                            state <= RESP;
                            if (winner == GNT_F) begin
                                f_ack <= 1'b1;
                                f_err <= 1'b1;
                            end else begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end
                        end else begin
                            state     <= ISSUE;
                            m_en      <= 1'b1;
                            m_addr    <= sel_addr;
                            m_rw      <= sel_we ? RW_WRITE : RW_READ;
                            m_data_in <= sel_wdata;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    state <= RESP;
                    if (gnt == GNT_F) begin
                        f_ack   <= 1'b1;
                        f_rdata <= m_data_out;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= gnt_we ? '0 : m_data_out;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-schedule model.
module tb_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              f_req, d_req, d_we;
    logic [ADDR_W-1:0] f_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              f_ack, f_err, d_ack, d_err;
    logic [DATA_W-1:0] f_rdata, d_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data_in, m_data_out;
    logic              m_rw, m_en;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_ack      (f_ack),
        .f_rdata    (f_rdata),
        .f_err      (f_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_data_out (m_data_out),
        .m_rw       (m_rw),
        .m_en       (m_en)
    );

    // Single-ported memory with a registered read, as seen by the arbiter.
    logic [31:0] mem [64];
    always @(posedge clock) begin
        if (m_en) begin
            if (m_rw) m_data_out <= mem[m_addr[7:2]];
            else      mem[m_addr[7:2]] <= m_data_in;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference model: each grant books its future events into a cycle ring.
    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic        fack, ferr, dack, derr;
        logic [31:0] fdata, ddata;
    } slot_t;

    logic [31:0] ref_mem [64];
    slot_t       sched [8];
    slot_t       cur;
    int          cyc     = 0;
    int          idle_at = 0;
    int          mstarve = 0;
    bit          chk_en  = 0;
    bit          f_seen  = 0;
    bit          d_seen  = 0;
    bit          m_fwin, m_we;
    logic [31:0] m_a;
    int          s1, s3;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        cur = sched[cyc % 8];
        if (chk_en) begin
            check("ctl", {f_ack, f_err, d_ack, d_err, m_en},
                  {cur.fack, cur.ferr, cur.dack, cur.derr, cur.en});
            if (cur.fack || cur.dack) begin
                check("f_rdata", f_rdata, cur.fdata);
                check("d_rdata", d_rdata, cur.ddata);
            end
            if (cur.en) begin
                check("m_addr", m_addr, cur.addr);
                check("m_rw", m_rw, cur.rw);
                if (!cur.rw) check("m_data_in", m_data_in, cur.wdata);
            end
        end
        sched[cyc % 8] = '0;
        f_seen = f_ack;
        d_seen = d_ack;

        if (reset) begin
            for (int i = 0; i < 8; i++) sched[i] = '0;
            idle_at = cyc + 1;
            mstarve = 0;
        end else if (cyc >= idle_at && (f_req || d_req)) begin
            m_fwin  = f_req && (!d_req || mstarve == STARVE_LIMIT);
            m_a     = m_fwin ? f_addr : d_addr;
            m_we    = !m_fwin && d_we;
            mstarve = (m_fwin || !f_req) ? 0 : (mstarve < STARVE_LIMIT ? mstarve + 1 : mstarve);
            s1 = (cyc + 1) % 8;
            s3 = (cyc + 3) % 8;
            if (m_a[1:0] != 2'b00) begin
                if (m_fwin) begin sched[s1].fack = 1; sched[s1].ferr = 1; end
                else        begin sched[s1].dack = 1; sched[s1].derr = 1; end
                idle_at = cyc + 2;
            end else begin
                sched[s1].en    = 1;
                sched[s1].addr  = m_a;
                sched[s1].rw    = !m_we;
                sched[s1].wdata = d_wdata;
                if (m_fwin) begin
                    sched[s3].fack  = 1;
                    sched[s3].fdata = ref_mem[m_a[7:2]];
                end else begin
                    sched[s3].dack  = 1;
                    sched[s3].ddata = m_we ? 32'h0 : ref_mem[m_a[7:2]];
                end
                if (m_we) ref_mem[m_a[7:2]] = d_wdata;
                idle_at = cyc + 4;
            end
        end
    end

    // Called right at a posedge; presents one request and leaves at a posedge.
    task automatic txn(input bit side_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input bit exp_err, input string name);
        #1;
        if (side_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            f_req = 1; f_addr = addr;
        end
        @(negedge clock);
        @(negedge clock);
        if (exp_err) begin
            check({name, "_ack"}, side_d ? d_ack : f_ack, 1);
            check({name, "_err"}, side_d ? d_err : f_err, 1);
            check({name, "_rdata"}, side_d ? d_rdata : f_rdata, 0);
            check({name, "_en"}, m_en, 0);
        end else begin
            check({name, "_en"}, m_en, 1);
            check({name, "_rw"}, m_rw, !we);
            check({name, "_addr"}, m_addr, addr);
            @(negedge clock);
            check({name, "_early"}, side_d ? d_ack : f_ack, 0);
            @(negedge clock);
            check({name, "_ack"}, side_d ? d_ack : f_ack, 1);
            check({name, "_err"}, side_d ? d_err : f_err, 0);
            check({name, "_rdata"}, side_d ? d_rdata : f_rdata, exp_rdata);
        end
        @(posedge clock);
        #1;
        d_req = 0;
        f_req = 0;
        @(posedge clock);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    logic [5:0] seq;
    int         n_gnt;

    initial begin
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[0] = 32'hABCDABCD; ref_mem[0] = 32'hABCDABCD;
        mem[2] = 32'h12341234; ref_mem[2] = 32'h12341234;

        reset = 1;
        repeat (3) @(posedge clock);
        #1 chk_en = 1;
        @(negedge clock);
        check("rst_en", m_en, 0);
        check("rst_rw", m_rw, 1);
        check("rst_addr", m_addr, 0);
        check("rst_wdata", m_data_in, 0);
        check("rst_acks", {f_ack, f_err, d_ack, d_err}, 0);
        check("rst_rdata", {f_rdata, d_rdata}, 0);
        check("rst_starve", dut.u_starve.starve_cnt, 0);
        @(posedge clock);
        #1 reset = 0;
        @(posedge clock);

        txn(1, 1, 32'h04, 32'hDEFADEFA, 32'h0, 0, "store");
        txn(1, 0, 32'h04, 32'h0, 32'hDEFADEFA, 0, "load");

        // Contention: data first, fetch four cycles later.
        #1;
        f_req = 1; f_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h8;
        repeat (4) @(negedge clock);
        check("cont_d_ack", d_ack, 1);
        check("cont_d_rdata", d_rdata, 32'h12341234);
        check("cont_f_wait", f_ack, 0);
        @(posedge clock);
        #1 d_req = 0;
        repeat (4) @(negedge clock);
        check("cont_f_ack", f_ack, 1);
        check("cont_f_rdata", f_rdata, 32'hABCDABCD);
        @(posedge clock);
        #1 f_req = 0;
        @(posedge clock);

        // Starvation: both held, expect D D D D F D.
        #1;
        f_req = 1; f_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h8;
        seq = '0;
        n_gnt = 0;
        for (int k = 0; k < 60 && n_gnt < 6; k++) begin
            @(negedge clock);
            if (d_ack || f_ack) begin
                seq = {seq[4:0], f_ack};
                n_gnt++;
                if (d_ack && n_gnt == 4) check("starve_full", dut.u_starve.starve_cnt, 4);
                if (f_ack) check("starve_clear", dut.u_starve.starve_cnt, 0);
            end
        end
        check("starve_count", n_gnt, 6);
        check("starve_seq", seq, 6'b000010);
        @(posedge clock);
        #1 f_req = 0; d_req = 0;
        @(posedge clock);

        txn(1, 0, 32'h06, 32'h0, 32'h0, 1, "d_mis");
        txn(0, 0, 32'h01, 32'h0, 32'h0, 1, "f_mis");

        // Reset during the WAIT cycle of a load.
        #1;
        d_req = 1; d_we = 0; d_addr = 32'h0; d_wdata = 32'h5555AAAA;
        @(negedge clock);
        @(negedge clock);
        check("rw_issue", m_data_in, 32'h5555AAAA);
        @(posedge clock);
        #1 reset = 1;
        @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rw_ack", d_ack, 0);
        check("rw_en", m_en, 0);
        check("rw_rw", m_rw, 1);
        check("rw_addr", m_addr, 0);
        check("rw_wdata", m_data_in, 0);
        check("rw_rdata", d_rdata, 0);
        repeat (2) begin
            @(negedge clock);
            check("rw_noack", d_ack, 0);
        end
        @(negedge clock);
        check("rw_reack", d_ack, 1);
        check("rw_redata", d_rdata, 32'hABCDABCD);
        @(posedge clock);
        #1 d_req = 0;
        @(posedge clock);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            @(posedge clock);
            #1;
            reset = ($urandom_range(0, 249) == 0);
            if (f_req && f_seen) f_req = 0;
            if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req  = 1;
                f_addr = rand_addr();
            end
            if (d_req && d_seen) d_req = 0;
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req   = 1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
        end
        @(posedge clock);
        #1;
        reset = 0; f_req = 0; d_req = 0;
        repeat (8) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
